// File: rtl/vga_scanout_pkg.sv
// vga_scanout_pkg: shared 640x480@60 timing constants, framebuffer geometry and the region-flag bundle.
// Used by vga_scanout, vga_timing and the drawing datapath (FB_W/FB_H).
package vga_scanout_pkg;
   localparam logic [9:0] H_VIS    = 10'd640;
   localparam logic [9:0] H_FP     = 10'd16;
   localparam logic [9:0] H_SYNC   = 10'd96;
   localparam logic [9:0] H_BP     = 10'd48;
   localparam logic [9:0] H_TOTAL  = 10'd800;
   localparam logic [9:0] V_VIS    = 10'd480;
   localparam logic [9:0] V_FP     = 10'd10;
   localparam logic [9:0] V_SYNC   = 10'd2;
   localparam logic [9:0] V_BP     = 10'd33;
   localparam logic [9:0] V_TOTAL  = 10'd525;
   localparam logic [7:0] FB_W     = 8'd160;
   localparam logic [6:0] FB_H     = 7'd120;
   localparam int         COLOUR_W = 3;

   typedef struct packed {
      logic h_vis;
      logic v_vis;
      logic h_sync;
      logic v_sync;
   } region_t;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-enable divider, raster counters, frame wrap pulse and raw region flags.
// Ports: clk, reset (sync, active-high); pix_en_o (toggles every clk); h_cnt_o/v_cnt_o raster position;
//        region_o visible/sync flags for the current position; frame_done_o 1-clk pulse on frame wrap.
module vga_timing #(
   parameter logic [9:0] H_VIS = vga_scanout_pkg::H_VIS,
   parameter logic [9:0] V_VIS = vga_scanout_pkg::V_VIS
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic                      pix_en_o,
   output logic [9:0]                h_cnt_o,
   output logic [9:0]                v_cnt_o,
   output vga_scanout_pkg::region_t  region_o,
   output logic                      frame_done_o
);
   import vga_scanout_pkg::*;

   // porches and sync widths stay fixed; totals follow the visible size
   localparam logic [9:0] H_SYNC_LO = H_VIS + H_FP;
   localparam logic [9:0] H_SYNC_HI = H_SYNC_LO + H_SYNC;
   localparam logic [9:0] H_LAST    = H_SYNC_HI + H_BP - 10'd1;
   localparam logic [9:0] V_SYNC_LO = V_VIS + V_FP;
   localparam logic [9:0] V_SYNC_HI = V_SYNC_LO + V_SYNC;
   localparam logic [9:0] V_LAST    = V_SYNC_HI + V_BP - 10'd1;

   logic       pix_en_q, frame_done_q, h_end, v_end;
   logic [9:0] h_q, h_d, v_q, v_d;

   assign h_end = h_q == H_LAST;
   assign v_end = v_q == V_LAST;
   assign h_d   = !pix_en_q ? h_q : h_end ? '0 : h_q + 10'd1;
   assign v_d   = !(pix_en_q && h_end) ? v_q : v_end ? '0 : v_q + 10'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         pix_en_q     <= 1'b0;
         h_q          <= '0;
         v_q          <= '0;
         frame_done_q <= 1'b0;
      end else begin
         pix_en_q     <= ~pix_en_q;
         h_q          <= h_d;
         v_q          <= v_d;
         frame_done_q <= pix_en_q && h_end && v_end;
      end
   end

   assign pix_en_o        = pix_en_q;
   assign h_cnt_o         = h_q;
   assign v_cnt_o         = v_q;
   assign frame_done_o    = frame_done_q;
   assign region_o.h_vis  = h_q < H_VIS;
   assign region_o.v_vis  = v_q < V_VIS;
   assign region_o.h_sync = h_q >= H_SYNC_LO && h_q < H_SYNC_HI;
   assign region_o.v_sync = v_q >= V_SYNC_LO && v_q < V_SYNC_HI;
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: raster-order reader of a 160x120 3-bit framebuffer driving a 640x480@60 VGA DAC, 4x4 pixel replication.
// Ports: clk, reset (sync, active-high); rd_addr/rd_data framebuffer read port (data 1 clk after address);
//        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R/G/B to the DAC; frame_done 1-clk frame wrap pulse.
// Option: define VGA_SCANOUT_TESTPAT_EN to add test_pattern (colour bars from h_cnt[9:7] instead of rd_data).
module vga_scanout #(
   parameter logic [9:0] H_VIS = vga_scanout_pkg::H_VIS,
   parameter logic [9:0] V_VIS = vga_scanout_pkg::V_VIS,
   parameter logic [7:0] FB_W  = vga_scanout_pkg::FB_W
) (
   input  logic                                  clk,
   input  logic                                  reset,
`ifdef VGA_SCANOUT_TESTPAT_EN
   input  logic                                  test_pattern,
`endif
   output logic [14:0]                           rd_addr,
   input  logic [vga_scanout_pkg::COLOUR_W-1:0]  rd_data,
   output logic                                  VGA_CLK,
   output logic                                  VGA_HS,
   output logic                                  VGA_VS,
   output logic                                  VGA_BLANK_N,
   output logic                                  VGA_SYNC_N,
   output logic [9:0]                            VGA_R,
   output logic [9:0]                            VGA_G,
   output logic [9:0]                            VGA_B,
   output logic                                  frame_done
);
   import vga_scanout_pkg::*;

   logic                pix_en, vis, hs_q, vs_q, blank_n_q, vga_clk_q;
   logic [9:0]          h_cnt, v_cnt;
   region_t             rg;
   logic [COLOUR_W-1:0] colour, rgb_d, rgb_q;

   vga_timing #(.H_VIS(H_VIS), .V_VIS(V_VIS)) u_timing (
      .clk          (clk),
      .reset        (reset),
      .pix_en_o     (pix_en),
      .h_cnt_o      (h_cnt),
      .v_cnt_o      (v_cnt),
      .region_o     (rg),
      .frame_done_o (frame_done)
   );

   assign vis     = rg.h_vis && rg.v_vis;
   // combinational from the counters, so it holds for both clks of a pixel
   assign rd_addr = vis ? 15'(v_cnt >> 2) * 15'(FB_W) + 15'(h_cnt >> 2) : '0;

`ifdef VGA_SCANOUT_TESTPAT_EN
   assign colour = test_pattern ? h_cnt[9:7] : rd_data;
`else
   assign colour = rd_data;
`endif
   assign rgb_d = vis ? colour : '0;

   // output stage loads on the pix_en edge, when rd_data belongs to the current counters
   always_ff @(posedge clk) begin
      if (reset) begin
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
         rgb_q     <= '0;
         vga_clk_q <= 1'b1;
      end else begin
         vga_clk_q <= pix_en;
         if (pix_en) begin
            hs_q      <= ~rg.h_sync;
            vs_q      <= ~rg.v_sync;
            blank_n_q <= vis;
            rgb_q     <= rgb_d;
         end
      end
   end

   assign VGA_CLK     = vga_clk_q;
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK_N = blank_n_q;
   assign VGA_SYNC_N  = 1'b0;
   assign VGA_R       = {10{rgb_q[2]}};
   assign VGA_G       = {10{rgb_q[1]}};
   assign VGA_B       = {10{rgb_q[0]}};
endmodule
